// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with a Mealy detect output, a registered copy
// of it, and a saturating match counter. Overlap or non-overlap mode is selectable per cycle.
module seq_detector_param #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1001,
  parameter int                   CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 in_valid,
  input  logic                 overlap,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 pattern_load,
  output logic                 data_out,
  output logic                 match_q,
  output logic [CNT_W-1:0]     match_count,
  output logic [PATTERN_W-1:0] pattern_q
);

  localparam int FILL_W = $clog2(PATTERN_W) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PATTERN_W-2:0] hist;
  logic [FILL_W-1:0]    fill;
  logic [PATTERN_W-1:0] shift_word;

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    return (f == FILL_MAX) ? f : f + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Candidate window: the held history with the current bit appended as the newest (LSB).
  assign shift_word = {hist, data_in};

  assign data_out = ~rst & in_valid & ~pattern_load & (fill == FILL_MAX) &
                    (shift_word == pattern_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= PATTERN_RST;
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      match_q <= data_out;
      if (data_out)
        match_count <= sat_cnt(match_count);
      if (pattern_load) begin
        pattern_q <= pattern_in;
        fill      <= '0;
      end else if (in_valid) begin
        hist <= shift_word[PATTERN_W-2:0];
        // Non-overlap restarts the window after a hit; hist keeps shifting regardless.
        if (data_out && !overlap)
          fill <= '0;
        else
          fill <= sat_fill(fill);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: table of stimulus/expected records with a scoreboard queue,
// plus a hand-written saturation sequence on a second instance with a 2-bit counter.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, data_in, in_valid, overlap, pattern_load;
  logic [3:0] pattern_in;
  logic       data_out, match_q;
  logic [7:0] match_count;
  logic [3:0] pattern_q;
  logic       data_out2, match_q2;
  logic [1:0] match_count2;
  logic [3:0] pattern_q2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_W(4), .PATTERN_RST(4'b1001), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .overlap(overlap),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .data_out(data_out),
    .match_q(match_q), .match_count(match_count), .pattern_q(pattern_q)
  );

  seq_detector_param #(.PATTERN_W(4), .PATTERN_RST(4'b1001), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .overlap(overlap),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .data_out(data_out2),
    .match_q(match_q2), .match_count(match_count2), .pattern_q(pattern_q2)
  );

  typedef struct {
    logic       rst, vld, din, ovl, ld;
    logic [3:0] pin;
    logic       exp_do;
    logic [7:0] exp_cnt;
    logic [3:0] exp_pat;
  } vec_t;

  typedef struct {
    logic       mq;
    logic [7:0] cnt;
    logic [3:0] pat;
  } reg_t;

  vec_t tbl[$];
  logic comb_q[$];
  reg_t reg_q[$];

  function automatic void add(input logic r, input logic v, input logic d, input logic o,
                              input logic l, input logic [3:0] p, input logic e,
                              input logic [7:0] c, input logic [3:0] pq);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.ovl = o; x.ld = l; x.pin = p;
    x.exp_do = e; x.exp_cnt = c; x.exp_pat = pq;
    tbl.push_back(x);
  endfunction

  // Shorthand for a plain accepted bit.
  function automatic void bitv(input logic d, input logic o, input logic e,
                               input logic [7:0] c, input logic [3:0] pq);
    add(1'b0, 1'b1, d, o, 1'b0, 4'h0, e, c, pq);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    logic e;
    reg_t r;
    rst = v.rst; in_valid = v.vld; data_in = v.din; overlap = v.ovl;
    pattern_load = v.ld; pattern_in = v.pin;
    comb_q.push_back(v.exp_do);
    r.mq = v.exp_do; r.cnt = v.exp_cnt; r.pat = v.exp_pat;
    reg_q.push_back(r);
    @(negedge clk);
    if (comb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_comb[%0d]: got empty expected entry", idx);
    end else begin
      e = comb_q.pop_front();
      check($sformatf("data_out[%0d]", idx), {31'd0, data_out}, {31'd0, e});
    end
    @(posedge clk); #1;
    if (reg_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_reg[%0d]: got empty expected entry", idx);
    end else begin
      r = reg_q.pop_front();
      check($sformatf("match_q[%0d]", idx), {31'd0, match_q}, {31'd0, r.mq});
      check($sformatf("match_count[%0d]", idx), {24'd0, match_count}, {24'd0, r.cnt});
      check($sformatf("pattern_q[%0d]", idx), {28'd0, pattern_q}, {28'd0, r.pat});
    end
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b0; in_valid = 1'b0; overlap = 1'b0;
    pattern_load = 1'b0; pattern_in = 4'h0;

    // Overlap stream 1,0,0,1,0,0,1: hits on bits 4 and 7
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 4'h9);
    bitv(1, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
    bitv(1, 1, 1, 1, 4'h9); bitv(0, 1, 0, 1, 4'h9); bitv(0, 1, 0, 1, 4'h9);
    bitv(1, 1, 1, 2, 4'h9);
    // Same stream non-overlapping: only bit 4
    add(1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h9);
    bitv(1, 0, 0, 0, 4'h9); bitv(0, 0, 0, 0, 4'h9); bitv(0, 0, 0, 0, 4'h9);
    bitv(1, 0, 1, 1, 4'h9); bitv(0, 0, 0, 1, 4'h9); bitv(0, 0, 0, 1, 4'h9);
    bitv(1, 0, 0, 1, 4'h9);
    // Bubbles (data_in=1 while invalid) do not break the partial match
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 4'h9);
    bitv(1, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
    add(0, 0, 1, 1, 0, 4'h0, 0, 0, 4'h9);
    add(0, 0, 1, 0, 0, 4'h0, 0, 0, 4'h9);
    add(0, 0, 1, 1, 0, 4'h0, 0, 0, 4'h9);
    bitv(0, 1, 0, 0, 4'h9); bitv(1, 1, 1, 1, 4'h9);
    // Load beats a would-be match; then the new pattern 1101 needs four fresh bits
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 4'h9);
    bitv(1, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
    add(0, 1, 1, 1, 1, 4'hD, 0, 0, 4'hD);
    bitv(1, 1, 0, 0, 4'hD); bitv(1, 1, 0, 0, 4'hD); bitv(0, 1, 0, 0, 4'hD);
    bitv(1, 1, 1, 1, 4'hD);
    // Reset restores the pattern; reset mid-pattern with a matching bit gives no detect
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 4'h9);
    bitv(1, 1, 0, 0, 4'h9); bitv(0, 0, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
    add(1, 1, 1, 1, 0, 4'h0, 0, 0, 4'h9);
    bitv(1, 1, 0, 0, 4'h9); bitv(0, 0, 0, 0, 4'h9); bitv(0, 1, 0, 0, 4'h9);
    bitv(1, 1, 1, 1, 4'h9);

    foreach (tbl[i]) apply(i, tbl[i]);

    // Saturating counter on the 2-bit instance: pattern 1111 fed nine ones in overlap mode
    rst = 1'b1; in_valid = 1'b0; pattern_load = 1'b0; data_in = 1'b0; overlap = 1'b1;
    @(posedge clk); #1;
    check("cnt2_reset", {30'd0, match_count2}, 32'd0);
    rst = 1'b0; pattern_load = 1'b1; pattern_in = 4'hF;
    @(posedge clk); #1;
    check("pattern_q2_load", {28'd0, pattern_q2}, 32'hF);
    pattern_load = 1'b0; in_valid = 1'b1; data_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      logic       exp_hit;
      logic [1:0] exp_c;
      exp_hit = (i >= 4);
      exp_c   = (i < 4) ? 2'd0 : (i - 3 >= 3) ? 2'd3 : 2'(i - 3);
      @(negedge clk);
      check($sformatf("data_out2[%0d]", i), {31'd0, data_out2}, {31'd0, exp_hit});
      @(posedge clk); #1;
      check($sformatf("match_q2[%0d]", i), {31'd0, match_q2}, {31'd0, exp_hit});
      check($sformatf("match_count2[%0d]", i), {30'd0, match_count2}, {30'd0, exp_c});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("match_q2_idle", {31'd0, match_q2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
